// File: rtl/pmu_pkg.sv
// pmu_pkg: definitions shared by the PMU counter bank and its per-tile
// counter block. Holds the config-register bit positions, the register map
// offsets (which depend on the event count of the tile), and the packed
// config register type with its reset value.
package pmu_pkg;

  // Config register bit positions.
  localparam int CFG_EN     = 0;
  localparam int CFG_CLR    = 1;
  localparam int CFG_FREEZE = 2;
  localparam int CFG_IRQEN  = 3;

  // Per-tile register map: counters occupy 0..event_count-1, and the two
  // control registers follow directly after them.
  function automatic int cfg_idx(input int event_count);
    return event_count;
  endfunction

  function automatic int ovf_idx(input int event_count);
    return event_count + 1;
  endfunction

  // Field order is MSB first, so en lands on bit 0 of the packed value.
  typedef struct packed {
    logic irq_en;  // bit 3
    logic freeze;  // bit 2
    logic clr;     // bit 1, write-only pulse, always stored as 0
    logic en;      // bit 0
  } pmu_cfg_t;

  localparam pmu_cfg_t CFG_RESET = '{irq_en: 1'b0, freeze: 1'b0, clr: 1'b0, en: 1'b1};

endpackage

// File: rtl/pmu_tile_counters.sv
// pmu_tile_counters: event counters, config and overflow status of one tile.
//
// Ports:
//   clk    clock
//   rst    asynchronous active-low reset
//   sig    event strobes, one count per cycle while high and enabled
//   wr_en  decoded, error-free register write aimed at this tile
//   idx    register index, shared by the write port and the read mux
//   wdata  write data
//   rdata  combinational read data for idx (zero-extended)
//   irq    registered tile interrupt: ovf_status != 0 && irq_en
module pmu_tile_counters
  import pmu_pkg::*;
#(
  parameter int EVENT_COUNT   = 23,
  parameter int COUNTER_WIDTH = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int REG_IDX_W     = $clog2(EVENT_COUNT + 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EVENT_COUNT-1:0] sig,
  input  logic                   wr_en,
  input  logic [REG_IDX_W-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   irq
);

  localparam logic [REG_IDX_W-1:0] CFG_REG = REG_IDX_W'(cfg_idx(EVENT_COUNT));
  localparam logic [REG_IDX_W-1:0] OVF_REG = REG_IDX_W'(ovf_idx(EVENT_COUNT));

  logic [COUNTER_WIDTH-1:0] cnt      [EVENT_COUNT];
  logic [COUNTER_WIDTH-1:0] cnt_next [EVENT_COUNT];
  logic [EVENT_COUNT-1:0]   ovf, ovf_next, wrap;
  pmu_cfg_t                 cfg, cfg_next, cfg_rd;
  logic                     wr_cfg, wr_ovf, clr;

  // Bits of wdata above COUNTER_WIDTH are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value held over and infer a latch.
  always_comb begin
    wr_cfg = wr_en && (idx == CFG_REG);
    wr_ovf = wr_en && (idx == OVF_REG);
    clr    = wr_cfg && wdata[CFG_CLR];
    wrap   = '0;

    // Priority per counter: clear, then register write, then increment.
    for (int e = 0; e < EVENT_COUNT; e++) begin
      cnt_next[e] = cnt[e];
      if (clr) begin
        cnt_next[e] = '0;
      end else if (wr_en && (idx == REG_IDX_W'(e))) begin
        cnt_next[e] = wdata[COUNTER_WIDTH-1:0];
      end else if (cfg.en && sig[e]) begin
        cnt_next[e] = cnt[e] + COUNTER_WIDTH'(1);
        wrap[e]     = &cnt[e];
      end
    end

    // W1C is applied before OR-ing in new wraps, so a wrap in the same
    // cycle as its clear keeps the bit set.
    ovf_next = wr_ovf ? (ovf & ~wdata[EVENT_COUNT-1:0]) : ovf;
    ovf_next = ovf_next | wrap;
    if (clr) ovf_next = '0;

    cfg_next = cfg;
    if (wr_cfg) begin
      cfg_next.en     = wdata[CFG_EN];
      cfg_next.clr    = 1'b0;
      cfg_next.freeze = wdata[CFG_FREEZE];
      cfg_next.irq_en = wdata[CFG_IRQEN];
    end else if (cfg.freeze && |wrap) begin
      cfg_next.en = 1'b0;
    end
  end

  // NOTE: the counter array is a bank of flops, not a RAM, so it is reset
  // element by element like any other state.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < EVENT_COUNT; e++) cnt[e] <= '0;
      ovf <= '0;
      cfg <= CFG_RESET;
      irq <= 1'b0;
    end else begin
      for (int e = 0; e < EVENT_COUNT; e++) cnt[e] <= cnt_next[e];
      ovf <= ovf_next;
      cfg <= cfg_next;
      irq <= (|ovf) && cfg.irq_en;
    end
  end

  // Read mux over the current state, i.e. before this cycle's update.
  always_comb begin
    cfg_rd     = cfg;
    cfg_rd.clr = 1'b0;
    rdata      = '0;
    for (int e = 0; e < EVENT_COUNT; e++) begin
      if (idx == REG_IDX_W'(e)) rdata = DATA_WIDTH'(cnt[e]);
    end
    if (idx == CFG_REG) rdata = DATA_WIDTH'(cfg_rd);
    if (idx == OVF_REG) rdata = DATA_WIDTH'(ovf);
  end

endmodule

// File: rtl/pmu_counter_bank.sv
// pmu_counter_bank: per-tile PMU event-counter bank with a valid/ready
// register request/response interface.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   pmu_sig_i    event strobes, tile t event e at bit t*EVENT_COUNT+e
//   req_valid_i  request valid
//   req_ready_o  request accepted when valid && ready
//   req_we_i     1 = write, 0 = read
//   req_addr_i   {tile, reg_idx}
//   req_wdata_i  write data
//   rsp_valid_o  response valid, held until rsp_ready_i
//   rsp_ready_i  response consumed
//   rsp_rdata_o  read data (0 for writes and errors)
//   rsp_err_o    address out of range
//   irq_o        OR of all registered tile interrupts
module pmu_counter_bank
  import pmu_pkg::*;
#(
  parameter int TILE_COUNT    = 1,
  parameter int EVENT_COUNT   = 23,
  parameter int COUNTER_WIDTH = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int REG_IDX_W     = $clog2(EVENT_COUNT + 2),
  parameter int TILE_IDX_W    = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TILE_COUNT*EVENT_COUNT-1:0] pmu_sig_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic                              req_we_i,
  input  logic [TILE_IDX_W+REG_IDX_W-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]             req_wdata_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic                              irq_o
);

  logic [TILE_IDX_W-1:0] tile;
  logic [REG_IDX_W-1:0]  reg_idx;
  logic                  accept, addr_err;
  logic [DATA_WIDTH-1:0] tile_rdata [TILE_COUNT];
  logic [TILE_COUNT-1:0] tile_irq;
  logic [DATA_WIDTH-1:0] rd_sel;

  assign {tile, reg_idx} = req_addr_i;

  // A new request may enter whenever the response slot is free or is being
  // drained in this same cycle.
  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign addr_err    = (32'(tile) >= 32'(TILE_COUNT)) ||
                       (32'(reg_idx) > 32'(ovf_idx(EVENT_COUNT)));

  for (genvar t = 0; t < TILE_COUNT; t++) begin : g_tile
    pmu_tile_counters #(
      .EVENT_COUNT  (EVENT_COUNT),
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .REG_IDX_W    (REG_IDX_W)
    ) u_tile (
      .clk  (clk),
      .rst  (rst),
      .sig  (pmu_sig_i[t*EVENT_COUNT +: EVENT_COUNT]),
      .wr_en(accept && req_we_i && !addr_err && (tile == TILE_IDX_W'(t))),
      .idx  (reg_idx),
      .wdata(req_wdata_i),
      .rdata(tile_rdata[t]),
      .irq  (tile_irq[t])
    );
  end

  always_comb begin
    rd_sel = '0;
    for (int t = 0; t < TILE_COUNT; t++) begin
      if (tile == TILE_IDX_W'(t)) rd_sel = tile_rdata[t];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_err_o   <= addr_err;
      rsp_rdata_o <= (req_we_i || addr_err) ? '0 : rd_sel;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  assign irq_o = |tile_irq;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Directed bench for pmu_counter_bank with three tiles (non-power-of-two
// tile count), 23 events and 64-bit counters. Expected responses are
// queued when a request is driven and compared when the DUT delivers them.
module tb_pmu_counter_bank;

  localparam int TC = 3;
  localparam int EC = 23;
  localparam int CW = 64;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int TW = 2;
  localparam int AW = TW + RW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [TC*EC-1:0]  pmu_sig_i = '0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic              req_we_i = 1'b0;
  logic [AW-1:0]     req_addr_i = '0;
  logic [DW-1:0]     req_wdata_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b1;
  logic [DW-1:0]     rsp_rdata_o;
  logic              rsp_err_o;
  logic              irq_o;

  always #5 clk = ~clk;

  pmu_counter_bank #(
    .TILE_COUNT   (TC),
    .EVENT_COUNT  (EC),
    .COUNTER_WIDTH(CW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pmu_sig_i  (pmu_sig_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i   (req_we_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .irq_o      (irq_o)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [AW-1:0] addr(input int t, input int r);
    return {TW'(t), RW'(r)};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait (bounded) for acceptance, and queue the
  // expected response at the moment it is accepted.
  task automatic do_req(input logic we, input int t, input int r, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd, input logic exp_err, input string tag);
    int waited = 0;
    exp_t e;
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr(t, r);
    req_wdata_i = wd;
    @(negedge clk);
    while (!req_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready_o) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_accept_timeout: observed ready=0, expected ready=1", tag);
    end else begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.tag   = tag;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", DW'(exp_q.size()), '0);
  endtask

  // Response monitor: pops and compares on every consumed response.
  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_rsp: observed rdata=%0h err=%b, expected no response",
               rsp_rdata_o, rsp_err_o);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        assert (rsp_rdata_o === e.rdata && rsp_err_o === e.err) else begin
          n_bad++;
          $error("FAIL %s: observed rdata=%0h err=%b, expected rdata=%0h err=%b",
                 e.tag, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    exp_t e2;

    // 1. Reset state and reset register values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", DW'(rsp_valid_o), '0);
    check("rst_rsp_rdata", rsp_rdata_o, '0);
    check("rst_rsp_err", DW'(rsp_err_o), '0);
    check("rst_irq", DW'(irq_o), '0);
    rst = 1'b1;
    check("rst_req_ready", DW'(req_ready_o), 64'd1);
    do_req(1'b0, 0, EC, '0, 64'h1, 1'b0, "rd_cfg_reset");
    do_req(1'b0, 0, 0, '0, 64'h0, 1'b0, "rd_cnt_reset");

    // 2. Ten strobes on tile1 event5 only.
    @(posedge clk); #1;
    pmu_sig_i[1*EC+5] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    pmu_sig_i[1*EC+5] = 1'b0;
    do_req(1'b0, 1, 5, '0, 64'd10, 1'b0, "rd_t1_e5");
    do_req(1'b0, 0, 5, '0, 64'd0, 1'b0, "rd_t0_e5");
    do_req(1'b0, 1, 4, '0, 64'd0, 1'b0, "rd_t1_e4");

    // 3. Wrap with freeze and interrupt; event4 counts alongside.
    do_req(1'b1, 0, 3, 64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b0, "wr_t0_e3");
    do_req(1'b1, 0, EC, 64'hD, '0, 1'b0, "wr_t0_cfg");
    pmu_sig_i[0*EC+3] = 1'b1;
    pmu_sig_i[0*EC+4] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pmu_sig_i[0*EC+3] = 1'b0;
    pmu_sig_i[0*EC+4] = 1'b0;
    check("irq_after_wrap", DW'(irq_o), 64'd1);
    do_req(1'b0, 0, 3, '0, 64'd0, 1'b0, "rd_t0_e3_wrapped");
    do_req(1'b0, 0, EC + 1, '0, 64'h8, 1'b0, "rd_t0_ovf");
    do_req(1'b0, 0, EC, '0, 64'hC, 1'b0, "rd_t0_cfg_frozen");
    do_req(1'b0, 0, 4, '0, 64'd2, 1'b0, "rd_t0_e4");
    do_req(1'b1, 0, EC + 1, 64'h8, '0, 1'b0, "w1c_t0_ovf");
    check("irq_one_cycle_after_w1c", DW'(irq_o), 64'd1);
    @(posedge clk); #1;
    check("irq_cleared", DW'(irq_o), 64'd0);
    drain();

    // 4. Backpressure: response held stable, second request stalled.
    rsp_ready_i = 1'b0;
    do_req(1'b0, 1, 5, '0, 64'd10, 1'b0, "bp_first");
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = addr(0, 4);
    check("bp_req_ready_low", DW'(req_ready_o), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("bp_rsp_valid_held", DW'(rsp_valid_o), 64'd1);
      check("bp_rsp_data_held", rsp_rdata_o, 64'd10);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    #1;
    check("bp_req_ready_high", DW'(req_ready_o), 64'd1);
    e2.rdata = 64'd2;
    e2.err   = 1'b0;
    e2.tag   = "bp_second";
    exp_q.push_back(e2);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    drain();

    // 5. Write beats a simultaneous strobe; then clear via cfg.
    pmu_sig_i[2*EC+7] = 1'b1;
    do_req(1'b1, 2, 7, 64'd100, '0, 1'b0, "wr_t2_e7");
    pmu_sig_i[2*EC+7] = 1'b0;
    do_req(1'b0, 2, 7, '0, 64'd100, 1'b0, "rd_t2_e7_no_inc");
    do_req(1'b1, 2, 0, {DW{1'b1}}, '0, 1'b0, "wr_t2_e0_ones");
    pmu_sig_i[2*EC+0] = 1'b1;
    @(posedge clk); #1;
    pmu_sig_i[2*EC+0] = 1'b0;
    do_req(1'b0, 2, EC + 1, '0, 64'h1, 1'b0, "rd_t2_ovf_set");
    pmu_sig_i[2*EC+1] = 1'b1;
    do_req(1'b1, 2, EC, 64'h3, '0, 1'b0, "wr_t2_clear");
    pmu_sig_i[2*EC+1] = 1'b0;
    do_req(1'b0, 2, 1, '0, 64'd0, 1'b0, "rd_t2_e1_cleared");
    do_req(1'b0, 2, 7, '0, 64'd0, 1'b0, "rd_t2_e7_cleared");
    do_req(1'b0, 2, EC + 1, '0, 64'h0, 1'b0, "rd_t2_ovf_cleared");
    do_req(1'b0, 2, EC, '0, 64'h1, 1'b0, "rd_t2_cfg_after_clear");

    // 6. Out-of-range accesses.
    do_req(1'b0, 0, EC + 2, '0, 64'd0, 1'b1, "err_reg_idx");
    do_req(1'b0, 3, 0, '0, 64'd0, 1'b1, "err_tile");
    do_req(1'b1, 3, 5, 64'h55, '0, 1'b1, "err_wr_tile");
    do_req(1'b1, 1, 26, 64'h0, '0, 1'b1, "err_wr_reg");
    do_req(1'b0, 1, 5, '0, 64'd10, 1'b0, "rd_t1_e5_unchanged");
    do_req(1'b0, 1, EC, '0, 64'h1, 1'b0, "rd_t1_cfg_unchanged");
    drain();

    // Reset with a response pending drops it for good.
    rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = addr(0, 0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("rstmid_pending", DW'(rsp_valid_o), 64'd1);
    rst = 1'b0;
    #1;
    check("rstmid_dropped", DW'(rsp_valid_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_no_rsp", DW'(rsp_valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmu_counter_bank.md
Name: pmu_counter_bank

Overview:
Parametrised per-tile event-counter bank, successor to the NoC PMU counter array. It sits behind the PMU AXI-lite/NoC bridge and exposes one register window per tile. Each window holds EVENT_COUNT event counters, a config register and a W1C overflow-status register. Adds single-clock operation, a valid/ready request and response handshake, per-tile addressing, overflow detection, freeze-on-overflow and an interrupt output.

Parameters:
TILE_COUNT, 1, number of tiles monitored
EVENT_COUNT, 23, event inputs and counters per tile (1..62)
COUNTER_WIDTH, 64, counter width in bits (16..64)
DATA_WIDTH, 64, register access data width (>= COUNTER_WIDTH, >= EVENT_COUNT)
REG_IDX_W, $clog2(EVENT_COUNT+2), derived: register index bits per tile
TILE_IDX_W, max(1,$clog2(TILE_COUNT)), derived: tile index bits

Ports:
clk  in  1  clock for all logic
rst  in  1  asynchronous, active-low reset
pmu_sig_i  in  TILE_COUNT*EVENT_COUNT  event strobes; one count per cycle when high
req_valid_i  in  1  register request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  TILE_IDX_W+REG_IDX_W  {tile, reg_idx}
req_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err_o  out  1  address out of range
irq_o  out  1  level interrupt: any tile has (ovf_status != 0) && cfg.irq_en

Behaviour:
- Reset (rst=0, async): counters=0, cfg=0x1 (enable=1, other bits 0), ovf_status=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, irq_o=0.
- Register map per tile: reg_idx 0..EVENT_COUNT-1 are counters. reg_idx EVENT_COUNT is cfg: bit0 enable, bit1 clear (write-only pulse, reads 0), bit2 freeze_on_ovf, bit3 irq_en. reg_idx EVENT_COUNT+1 is ovf_status, bit e = counter e wrapped; write-1-to-clear.
- Error case: tile >= TILE_COUNT or reg_idx > EVENT_COUNT+1 gives rsp_err_o=1 and rdata=0. Writes with an error have no effect.
- Handshake: req_ready_o = ~rsp_valid_o | rsp_ready_i. One request outstanding at a time.
- Response timing: rsp_valid_o rises the cycle after acceptance and holds, with data stable, until rsp_ready_i. Back-to-back accepted requests give one response per cycle.
- Read data: sampled from register state in the accept cycle, before that cycle's updates. Counters are zero-extended to DATA_WIDTH.
- Counter update priority per cycle, highest first: clear > register write to that counter > increment.
- Increment: when enable=1 and the event strobe is high, counter <= counter+1 modulo 2^COUNTER_WIDTH.
- Wrap (all-ones +1 -> 0) sets ovf_status[e] in the same cycle. If freeze_on_ovf=1, enable is cleared in the same cycle; counts of other events in that cycle still apply.
- Simultaneous W1C of ovf_status and a new wrap on the same bit: the bit stays set.
- Clear: a cfg write with bit1=1 zeroes all counters and ovf_status of that tile next cycle. The other cfg bits are taken from the write data. Strobes in the write cycle are lost.
- Writes are zero-extended or truncated to COUNTER_WIDTH. cfg bits above 3 are ignored and read 0.
- irq_o is registered: 1 cycle after the ovf/irq_en state change.
- Reset mid-transaction drops any pending response. No response is issued after reset deasserts.

Decomposition:
- pmu_pkg holds cfg bit indices (CFG_EN=0, CFG_CLR=1, CFG_FREEZE=2, CFG_IRQEN=3), reg offsets as functions of EVENT_COUNT, and a typedef pmu_cfg_t packed struct.
- Sub-module pmu_tile_counters is instantiated TILE_COUNT times. It holds counters, cfg, ovf_status and the tile irq, and takes a decoded write strobe plus read mux index.
- The top level does decode, response register and irq OR.

Test Plan:
1. Reset then read tile0 reg EVENT_COUNT -> rdata=0x1, err=0. Read reg 0 -> 0.
2. Pulse pmu_sig_i[tile1][5] for 10 cycles, then read {1,5} -> 10; {0,5} -> 0.
3. Write counter {0,3}=2^64-2 with enable=1, cfg freeze=1, irq_en=1, then 3 strobes -> counter=0, ovf_status=0x8, enable=0, irq_o=1. Write ovf_status=0x8 -> irq_o=0 one cycle later.
4. Hold rsp_ready_i=0 with a second req_valid_i -> req_ready_o=0. The response stays stable until ready, then the second request is accepted that cycle.
5. Write a counter while its strobe is high -> read returns the written value, with no +1. Write cfg=0x3 -> all counters and ovf_status read 0 and cfg reads 0x1.
6. Read with reg_idx=EVENT_COUNT+2, or tile=TILE_COUNT when not a power of two -> err=1, rdata=0. State is unchanged after an erroneous write.
